// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Holds the FSM state encoding, parameter defaults and a width helper.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_STABLE_CYCLES     = 4;
  localparam int DEF_LONG_PRESS_CYCLES = 16;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Output q is the last stage of the chain.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw push-button, producing a clean level
// plus registered press, release and long-press strobes.
module button_debouncer
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES     = DEF_STABLE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic button_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int STAB_W = clog2(STABLE_CYCLES + 1);
  localparam int HOLD_W = clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  // With a one-sample window the wait states are skipped entirely.
  localparam bit PASS_THROUGH = (STABLE_CYCLES == 1);

  logic btn_s;

  state_t            state, state_nxt;
  logic [STAB_W-1:0] stab_cnt, stab_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              clean_nxt, press_nxt, release_nxt, long_nxt;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button),
    .q     (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      stab_cnt         <= '0;
      hold_cnt         <= '0;
      button_clean     <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      state            <= state_nxt;
      stab_cnt         <= stab_nxt;
      hold_cnt         <= hold_nxt;
      button_clean     <= clean_nxt;
      press_pulse      <= press_nxt;
      release_pulse    <= release_nxt;
      long_press_pulse <= long_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    stab_nxt    = stab_cnt;
    hold_nxt    = hold_cnt;
    clean_nxt   = button_clean;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (btn_s) begin
          if (PASS_THROUGH) begin
            state_nxt = PRESSED;
            clean_nxt = 1'b1;
            press_nxt = 1'b1;
            hold_nxt  = '0;
            stab_nxt  = '0;
          end else begin
            state_nxt = PRESS_WAIT;
            stab_nxt  = STAB_ONE;
          end
        end
      end

      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          stab_nxt  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = PRESSED;
          clean_nxt = 1'b1;
          press_nxt = 1'b1;
          hold_nxt  = '0;
          stab_nxt  = '0;
        end else begin
          stab_nxt = stab_cnt + STAB_ONE;
        end
      end

      PRESSED: begin
        // Saturating hold count; the strobe fires only on reaching the limit.
        if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_LAST) long_nxt = 1'b1;
        end
        if (!btn_s) begin
          if (PASS_THROUGH) begin
            state_nxt   = IDLE;
            clean_nxt   = 1'b0;
            release_nxt = 1'b1;
            hold_nxt    = '0;
            stab_nxt    = '0;
          end else begin
            state_nxt = RELEASE_WAIT;
            stab_nxt  = STAB_ONE;
          end
        end
      end

      RELEASE_WAIT: begin
        // A returning press resumes PRESSED with the hold count untouched.
        if (btn_s) begin
          state_nxt = PRESSED;
          stab_nxt  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt   = IDLE;
          clean_nxt   = 1'b0;
          release_nxt = 1'b1;
          hold_nxt    = '0;
          stab_nxt    = '0;
        end else begin
          stab_nxt = stab_cnt + STAB_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: reset, bounce rejection, long press,
// release glitch and asynchronous mid-press reset.
module tb_button_debouncer;

  logic clk;
  logic rst_n;
  logic button;
  logic button_clean;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;

  int compared   = 0;
  int mismatched = 0;
  int press_seen = 0;
  bit toggle_state = 1'b0;

  // Expected strobe sequence, one-hot {press, release, long}.
  logic [2:0] exp_q[$];
  logic [2:0] mon_obs;
  logic [2:0] mon_exp;

  button_debouncer #(
    .SYNC_STAGES       (2),
    .STABLE_CYCLES     (4),
    .LONG_PRESS_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .button           (button),
    .button_clean     (button_clean),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic c, input logic p,
                            input logic r, input logic l);
    check(tag, {button_clean, press_pulse, release_pulse, long_press_pulse}, {c, p, r, l});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every strobe must match the next expected event
  always @(negedge clk) begin
    if (rst_n && (press_pulse || release_pulse || long_press_pulse)) begin
      mon_obs = {press_pulse, release_pulse, long_press_pulse};
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
      check("pulse_seq", {1'b0, mon_obs}, {1'b0, mon_exp});
      if (press_pulse) begin
        press_seen++;
        toggle_state = ~toggle_state;
      end
    end
  end

  // Directed stimulus
  initial begin
    rst_n  = 1'b0;
    button = 1'b1;
    tick();
    tick();
    check_outs("reset_outs", 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 1 + 4: press out of reset, hold for a long press, then release
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_outs("t1_latency", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs("t1_press", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      check_outs("t4_hold", 1'b1, 1'b0, 1'b0, (i == 16));
    end
    button = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_outs("t4_release_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs("t4_release", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 2: alternating bounce is rejected
    for (int i = 0; i < 4; i++) begin
      button = (i % 2 == 0);
      tick();
      check_outs("t2_bounce", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    button = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_outs("t2_settle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Test 3: bouncy press then settle
    exp_q.push_back(3'b100);
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
    button = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_outs("t3_latency", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs("t3_press", 1'b1, 1'b1, 1'b0, 1'b0);

    // Test 5: two-cycle release glitch; hold count freezes for two cycles
    exp_q.push_back(3'b001);
    tick();
    tick();
    button = 1'b0;
    tick();
    tick();
    button = 1'b1;
    for (int i = 5; i <= 24; i++) begin
      tick();
      check_outs("t5_glitch", 1'b1, 1'b0, 1'b0, (i == 18));
    end
    exp_q.push_back(3'b010);
    button = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check_outs("t5_release", (i != 5), 1'b0, (i == 5), 1'b0);
    end

    // Test 6: asynchronous reset while pressed, button held through it
    exp_q.push_back(3'b100);
    button = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check_outs("t6_press", (i == 5), (i == 5), 1'b0, 1'b0);
    end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_outs("t6_async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("t6_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(3'b100);
    rst_n = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check_outs("t6_repress", (i == 5), (i == 5), 1'b0, 1'b0);
    end
    exp_q.push_back(3'b010);
    button = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check_outs("t6_release", (i != 5), 1'b0, (i == 5), 1'b0);
    end
    tick();

    // Final report
    check("queue_empty", 4'(exp_q.size()), 4'd0);
    check("press_count", 4'(press_seen), 4'd4);
    check("toggle_state", {3'b000, toggle_state}, 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for buttonFsm. Takes the raw, asynchronous, bouncing push-button level and synchronises it to clk. Filters it with a stability counter.
- Produces a clean level plus single-cycle press, release and long-press strobes.
- button_clean drives buttonFsm's button input directly, so the toggle FSM never sees bounce.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain (legal: 2..4).
- STABLE_CYCLES, 4, consecutive identical synchronised samples required to accept a level change (legal: >=1).
- LONG_PRESS_CYCLES, 16, cycles in PRESSED before long_press_pulse fires (legal: >=1).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- button  input  1  raw asynchronous button level, 1 = pressed, may bounce.
- button_clean  output  1  debounced level; feeds buttonFsm.button.
- press_pulse  output  1  one-cycle strobe when button_clean rises.
- release_pulse  output  1  one-cycle strobe when button_clean falls.
- long_press_pulse  output  1  one-cycle strobe, at most once per press, after a sustained hold.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0, the following are forced to 0 immediately, independent of clk: synchroniser flops, stability counter, hold counter, all four outputs. State is forced to IDLE.
- Synchroniser: button passes through SYNC_STAGES flops; the last stage is btn_s. Only btn_s is used by the FSM.
- Outputs: all outputs are registered; no combinational path from button to any output.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE (button_clean=0):
  - btn_s=1 -> PRESS_WAIT, stab_cnt=1.
  - Else stay.
- PRESS_WAIT (button_clean=0):
  - btn_s=0 -> IDLE, stab_cnt=0. This is a bounce rejection; no pulse.
  - btn_s=1 and stab_cnt=STABLE_CYCLES-1 -> PRESSED.
    - button_clean<=1, press_pulse<=1 for exactly one cycle.
    - hold_cnt=0.
  - Else stab_cnt+1.
- PRESSED (button_clean=1):
  - hold_cnt increments each cycle and saturates at LONG_PRESS_CYCLES.
  - When hold_cnt transitions to LONG_PRESS_CYCLES, long_press_pulse<=1 for one cycle. It never re-fires in the same press.
  - btn_s=0 -> RELEASE_WAIT, stab_cnt=1.
- RELEASE_WAIT (button_clean=1):
  - hold_cnt is frozen (neither counts nor clears).
  - btn_s=1 -> PRESSED. No press_pulse is generated; hold_cnt resumes from its frozen value.
  - btn_s=0 and stab_cnt=STABLE_CYCLES-1 -> IDLE.
    - button_clean<=0, release_pulse<=1 for one cycle.
    - hold_cnt=0.
  - Else stab_cnt+1.
- STABLE_CYCLES=1: PRESS_WAIT and RELEASE_WAIT are pass-through. Acceptance occurs on the first btn_s sample, with no extra cycle.
- Latency: a clean step on button is sampled at edge 0, and button_clean changes at edge SYNC_STAGES+STABLE_CYCLES-1. With defaults this is edge 5, i.e. 6 rising edges counting edge 0.
- Pulse exclusivity:
  - press_pulse and release_pulse are never high in the same cycle.
  - long_press_pulse never coincides with press_pulse.
- Counter widths: stab_cnt is clog2(STABLE_CYCLES+1) bits; hold_cnt is clog2(LONG_PRESS_CYCLES+1) bits. Neither counter wraps.
- Reset mid-operation: outputs drop to 0 at once; no release_pulse is emitted. If the button is held through reset deassertion, a fresh press_pulse follows after full latency.

Decomposition:
- Package button_pkg holds:
  - the 2-bit state typedef {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - default constants for the three parameters;
  - a clog2 width function.
- One sub-module: bit_synchronizer (parameter STAGES; ports clk, rst_n, d, q), instantiated once.
- FSM and counters stay in button_debouncer.

Test Plan:
1. Reset check: rst_n=0 at t=0 with button=1 -> all outputs 0. Release reset, hold button=1 -> button_clean=1 and press_pulse=1 for exactly one cycle, 6 edges after the first sampled 1.
2. Bounce reject: button toggles 1,0,1,0 every cycle, then stays 0 -> button_clean stays 0; press_pulse and release_pulse never assert.
3. Bouncy press then settle: button 1,0,1 then held 1 -> exactly one press_pulse; button_clean=1, 6 edges after the final 0->1.
4. Long press: hold button=1 for 30 cycles after acceptance -> one long_press_pulse, 16 cycles after press_pulse. Release -> one release_pulse; no second long_press_pulse.
5. Release glitch: while pressed, button=0 for 2 cycles then 1 -> button_clean stays 1 and no pulses. The hold count is preserved, so long_press still fires 16 PRESSED cycles after the press.
6. Mid-press reset: assert rst_n=0 while button_clean=1 -> outputs 0 asynchronously, before the next clk edge, with no release_pulse. Chain to buttonFsm -> stateful_button toggles exactly once per accepted press.
